// File: rtl/spi_ram_target.sv
// spi_ram_target: SPI mode-0 serial SRAM responder, fully clk-synchronous.
// Optional preload/inspect backdoor port: define SPI_RAM_TARGET_BACKDOOR_EN.
module spi_ram_target #(
    parameter int ADDR_BITS   = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_clk,
    input  logic                  spi_select,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  active,
    output logic                  err_cmd
`ifdef SPI_RAM_TARGET_BACKDOOR_EN
    ,
    input  logic                  bd_we,
    input  logic [DEPTH_LOG2-1:0] bd_addr,
    input  logic [7:0]            bd_wdata,
    output logic [7:0]            bd_rdata
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(ADDR_BITS) + 1;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, READ, WRITE, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync, sel_sync, mosi_sync;
    logic                   sck_prev, sel_prev;
    logic                   sck_s, sel_s, mosi_s;
    logic                   sck_rise, sck_fall, sel_rise, sel_fall;

    logic [7:0] mem [DEPTH];

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [7:0]             sh, sh_n, sh_in;
    logic [7:0]             obuf, obuf_n;
    logic [ADDR_BITS-1:0]   addr, addr_n, addr_in, addr_inc, fetch_addr;
    logic [7:0]             fetch_data;
    logic                   rd, rd_n;
    logic                   miso_n, err_n, active_n, we, last8;

    // Sync chains reset low so a select held low across reset never
    // produces a falling edge; it must rise and fall again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            sel_sync  <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            sel_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], spi_select};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
            sel_prev  <= sel_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sel_s    = sel_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign sel_rise = sel_s & ~sel_prev;
    assign sel_fall = ~sel_s & sel_prev;

    assign sh_in      = {sh[6:0], mosi_s};
    assign addr_in    = {addr[ADDR_BITS-2:0], mosi_s};
    assign addr_inc   = addr + ADDR_BITS'(1);
    assign last8      = (cnt == CW'(7));
    assign fetch_addr = (state == ADDR) ? addr_in : addr_inc;
    assign fetch_data = mem[fetch_addr[DEPTH_LOG2-1:0]];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        obuf_n  = obuf;
        addr_n  = addr;
        rd_n    = rd;
        miso_n  = spi_miso;
        err_n   = err_cmd;
        we      = 1'b0;
        if (sel_rise) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_fall) begin
                        state_n = CMD;
                        cnt_n   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        sh_n  = sh_in;
                        cnt_n = cnt + CW'(1);
                        if (last8) begin
                            cnt_n = '0;
                            if (sh_in == 8'h03) begin
                                state_n = ADDR;
                                rd_n    = 1'b1;
                            end else if (sh_in == 8'h02) begin
                                state_n = ADDR;
                                rd_n    = 1'b0;
                            end else begin
                                state_n = IGNORE;
                                err_n   = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_n = addr_in;
                        cnt_n  = cnt + CW'(1);
                        if (cnt == CW'(ADDR_BITS - 1)) begin
                            cnt_n = '0;
                            if (rd) begin
                                state_n = READ;
                                obuf_n  = fetch_data;
                            end else begin
                                state_n = WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (sck_fall) begin
                        miso_n = obuf[7];
                        obuf_n = {obuf[6:0], 1'b0};
                        cnt_n  = cnt + CW'(1);
                        if (last8) begin
                            cnt_n  = '0;
                            addr_n = addr_inc;
                            obuf_n = fetch_data;
                        end
                    end
                end
                WRITE: begin
                    if (sck_rise) begin
                        sh_n  = sh_in;
                        cnt_n = cnt + CW'(1);
                        if (last8) begin
                            we     = 1'b1;
                            cnt_n  = '0;
                            addr_n = addr_inc;
                        end
                    end
                end
                IGNORE: begin
                end
                default: state_n = IDLE;
            endcase
        end
        if (state_n != READ) miso_n = 1'b0;
        active_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            obuf     <= '0;
            addr     <= '0;
            rd       <= 1'b0;
            spi_miso <= 1'b0;
            err_cmd  <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sh       <= sh_n;
            obuf     <= obuf_n;
            addr     <= addr_n;
            rd       <= rd_n;
            spi_miso <= miso_n;
            err_cmd  <= err_n;
            active   <= active_n;
        end
    end

    // The SPI write comes last so it wins a same-index collision.
    always_ff @(posedge clk) begin
`ifdef SPI_RAM_TARGET_BACKDOOR_EN
        if (bd_we) mem[bd_addr] <= bd_wdata;
`endif
        if (we) mem[addr[DEPTH_LOG2-1:0]] <= sh_in;
    end

`ifdef SPI_RAM_TARGET_BACKDOOR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) bd_rdata <= 8'h00;
        else        bd_rdata <= mem[bd_addr];
    end
`endif

endmodule
